i2c_xfer_sequencer: RTL and testbench
=====================================

Name: i2c_xfer_sequencer

Overview:
- SFR-mapped transaction controller between the DW8051 SFR bus and the byte-level I2C master engine.
- Takes a slave address, direction and byte count from firmware, then sequences START, address byte, data bytes and STOP into the engine one command at a time.
- Buffers TX/RX bytes in small FIFOs and reports BUSY/DONE/NACK status, so firmware no longer polls each bit-phase.

Parameters:
- FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs (power of 2, ≥2).
- SFR_BASE, 8'h9A, address of CTRL; the other registers sit at fixed offsets +1..+5.

Ports:
- clk  in  1  system clock
- rst_in_n  in  1  asynchronous active-low reset
- sfr_wr  in  1  SFR write strobe, one cycle
- sfr_rd  in  1  SFR read strobe, one cycle
- sfr_addr  in  8  SFR address
- sfr_data_out  in  8  write data from the 8051
- sfr_data_in  out  8  read data to the 8051; combinational mux on sfr_addr
- eng_req  out  1  one-cycle command pulse to the engine
- eng_cmd  out  2  00 START, 01 WRITE, 10 READ, 11 STOP; held stable from eng_req until eng_done
- eng_wdata  out  8  byte for a WRITE; held with eng_cmd
- eng_ack_last  out  1  on a READ: 1 means the master NACKs this byte (last byte)
- eng_done  in  1  one-cycle completion pulse from the engine
- eng_rdata  in  8  read byte; valid with eng_done
- eng_nack  in  1  slave NACK on a WRITE; valid with eng_done
- irq  out  1  level interrupt = DONE & IRQ_EN

Behaviour:
- Clock and reset: one clock, clk. Asynchronous active-low reset, rst_in_n.
- Register map (offset from SFR_BASE):
  - +0 CTRL (W): b0 GO, b1 RNW, b3 IRQ_EN (sticky), b7 ABORT.
  - +1 STATUS (R): b0 BUSY, b1 DONE, b2 NACK, b3 TX_EMPTY, b4 RX_VALID, b5 TX_OVF.
  - +2 TXDATA (W): push to TX FIFO.
  - +3 RXDATA (R): pop from RX FIFO.
  - +4 SADDR (RW): 7-bit slave address, b7 reads 0.
  - +5 LEN (RW): 4-bit byte count, b7:4 read 0.
  - Any other address reads 8'h00 and writes are ignored.
- Side effects:
  - An sfr_rd of STATUS clears DONE, NACK and TX_OVF on the following edge.
  - An sfr_rd of RXDATA pops one entry. If the RX FIFO is empty it returns 8'h00 and nothing is popped.
  - A TXDATA write when the TX FIFO is full drops the byte and sets TX_OVF.
- Reset values:
  - eng_req=0, eng_cmd=00, eng_wdata=00, eng_ack_last=0, irq=0.
  - All registers 0; FIFOs empty; FSM in IDLE.
- FSM states: IDLE, START, ADDR, WR, WAIT_TX, RD, WAIT_RX, STOP.
  - Each command state pulses eng_req in its entry cycle, then waits for eng_done. At most one command is outstanding.
- IDLE:
  - GO=1 and ABORT=0 → latch SADDR/RNW/LEN into working copies, remaining count n=LEN, set BUSY, go to START.
  - GO while BUSY is ignored.
- START done → ADDR, which issues WRITE {SADDR,RNW}.
- ADDR done:
  - eng_nack=1 → set NACK, go to STOP.
  - else n==0 → STOP (address-only probe).
  - else RNW=0 → WR; RNW=1 → RD.
- WR:
  - If the TX FIFO is empty, go to WAIT_TX (no eng_req) until a byte arrives.
  - Otherwise pop the byte and issue WRITE.
  - On done: eng_nack=1 → set NACK, go to STOP; else decrement n, then n==0 → STOP, else WR.
- RD:
  - If the RX FIFO is full, go to WAIT_RX until a pop frees an entry.
  - Otherwise issue READ with eng_ack_last=(n==1).
  - On done: push eng_rdata, decrement n, then n==0 → STOP, else RD.
- STOP done → clear BUSY, set DONE, go to IDLE.
- ABORT:
  - In IDLE: flushes both FIFOs.
  - When BUSY: latched. The outstanding command completes, then the FSM goes to STOP. The FIFOs are flushed when STOP completes. DONE is set; NACK is unchanged.
  - From WAIT_TX or WAIT_RX: goes to STOP immediately.
- Simultaneous events:
  - A push and a pop of the same FIFO in one cycle keeps the count unchanged, and is legal when the FIFO is full or empty.
  - sfr_rd of STATUS in the same cycle that DONE is set: the read returns the old value; DONE is set, not cleared.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Reset mid-transaction: everything returns to reset values immediately. The engine must be reset by the same rst_in_n.

Test Plan:
- Write 2 bytes: SADDR=0x50, LEN=2, TXDATA 0xA5 then 0x3C, CTRL=0x01 → commands START, WRITE 0xA0, WRITE 0xA5, WRITE 0x3C, STOP. STATUS ends 0x0A: DONE=1, TX_EMPTY=1.
- Read 3 bytes: SADDR=0x50, LEN=3, CTRL=0x03 → WRITE 0xA1, then 3 READs with eng_ack_last=0,0,1. RXDATA returns 0x11, 0x22, 0x33 as supplied by the engine; a 4th read returns 0x00.
- Address NACK: eng_nack=1 on the address byte → STOP is issued with no data commands. STATUS reads 0x0E; an immediate second read returns 0x08.
- Backpressure: write with LEN=6 and TX pre-filled with 4 bytes → WAIT_TX after 4 bytes with no eng_req; 2 late TXDATA writes resume the transfer. A read with LEN=6 stalls in WAIT_RX after 4 bytes until RXDATA is popped.
- Overflow/abort: 5 TXDATA writes → TX_OVF=1 and the 5th byte is dropped. ABORT during the 2nd WRITE → that command completes, then STOP, then the FIFOs are empty and DONE=1.
- irq and reset: with IRQ_EN=1, irq rises after STOP and falls after a STATUS read. rst_in_n pulsed mid-READ → eng_req=0, STATUS=0x08, FSM in IDLE.

Source files
------------

// File: rtl/i2c_xfer_sequencer.sv
// SFR-mapped I2C transaction sequencer: turns firmware address/length/direction
// into START/addr/data/STOP commands for the byte engine, with TX/RX byte FIFOs.
module i2c_xfer_sequencer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  SFR_BASE   = 8'h9A
) (
   input  logic       clk,
   input  logic       rst_in_n,
   input  logic       sfr_wr,
   input  logic       sfr_rd,
   input  logic [7:0] sfr_addr,
   input  logic [7:0] sfr_data_out,
   output logic [7:0] sfr_data_in,
   output logic       eng_req,
   output logic [1:0] eng_cmd,
   output logic [7:0] eng_wdata,
   output logic       eng_ack_last,
   input  logic       eng_done,
   input  logic [7:0] eng_rdata,
   input  logic       eng_nack,
   output logic       irq
);

   localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   localparam logic [7:0] A_CTRL   = SFR_BASE;
   localparam logic [7:0] A_STATUS = SFR_BASE + 8'd1;
   localparam logic [7:0] A_TXDATA = SFR_BASE + 8'd2;
   localparam logic [7:0] A_RXDATA = SFR_BASE + 8'd3;
   localparam logic [7:0] A_SADDR  = SFR_BASE + 8'd4;
   localparam logic [7:0] A_LEN    = SFR_BASE + 8'd5;

   localparam logic [1:0] CMD_START = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b01;
   localparam logic [1:0] CMD_READ  = 2'b10;
   localparam logic [1:0] CMD_STOP  = 2'b11;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_START   = 3'd1;
   localparam logic [2:0] S_ADDR    = 3'd2;
   localparam logic [2:0] S_WR      = 3'd3;
   localparam logic [2:0] S_WAIT_TX = 3'd4;
   localparam logic [2:0] S_RD      = 3'd5;
   localparam logic [2:0] S_WAIT_RX = 3'd6;
   localparam logic [2:0] S_STOP    = 3'd7;

   logic [2:0]    state, state_nx;
   logic          busy, busy_nx, done, done_nx, nack, nack_nx, tx_ovf, tx_ovf_nx;
   logic          abort_pend, abort_pend_nx, irq_en, irq_en_nx, irq_nx;
   logic [6:0]    saddr, saddr_nx, w_saddr, w_saddr_nx;
   logic [3:0]    len, len_nx, n, n_nx;
   logic          w_rnw, w_rnw_nx;
   logic          req_nx, ack_nx;
   logic [1:0]    cmd_nx;
   logic [7:0]    wdata_nx;
   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_wp, tx_wp_nx, tx_rp, tx_rp_nx, rx_wp, rx_wp_nx, rx_rp, rx_rp_nx;
   logic [CW-1:0] tx_cnt, tx_cnt_nx, rx_cnt, rx_cnt_nx;
   logic          tx_pop, tx_push, rx_push, rx_push_ok, flush;
   logic          go_stop, go_wr, go_rd;

   logic ctrl_wr, go, abort, abort_any, tx_wr, rx_pop, status_rd;
   assign ctrl_wr   = sfr_wr && (sfr_addr == A_CTRL);
   assign go        = ctrl_wr && sfr_data_out[0];
   assign abort     = ctrl_wr && sfr_data_out[7];
   assign abort_any = abort || abort_pend;
   assign tx_wr     = sfr_wr && (sfr_addr == A_TXDATA);
   assign rx_pop    = sfr_rd && (sfr_addr == A_RXDATA) && (rx_cnt != '0);
   assign status_rd = sfr_rd && (sfr_addr == A_STATUS);

   // SFR read mux
   always_comb begin
      sfr_data_in = 8'h00;
      case (sfr_addr)
         A_STATUS: sfr_data_in = {2'b00, tx_ovf, rx_cnt != '0, tx_cnt == '0, nack, done, busy};
         A_RXDATA: sfr_data_in = (rx_cnt != '0) ? rx_mem[rx_rp] : 8'h00;
         A_SADDR:  sfr_data_in = {1'b0, saddr};
         A_LEN:    sfr_data_in = {4'h0, len};
         default:  sfr_data_in = 8'h00;
      endcase
   end

   // Next-state, command issue and FIFO bookkeeping
   always_comb begin
      state_nx      = state;
      busy_nx       = busy;
      done_nx       = done & ~status_rd;
      nack_nx       = nack & ~status_rd;
      tx_ovf_nx     = tx_ovf & ~status_rd;
      abort_pend_nx = abort_pend | (abort & busy);
      irq_en_nx     = ctrl_wr ? sfr_data_out[3] : irq_en;
      saddr_nx      = (sfr_wr && sfr_addr == A_SADDR) ? sfr_data_out[6:0] : saddr;
      len_nx        = (sfr_wr && sfr_addr == A_LEN) ? sfr_data_out[3:0] : len;
      w_saddr_nx    = w_saddr;
      w_rnw_nx      = w_rnw;
      n_nx          = n;
      req_nx        = 1'b0;
      cmd_nx        = eng_cmd;
      wdata_nx      = eng_wdata;
      ack_nx        = eng_ack_last;
      tx_pop        = 1'b0;
      tx_push       = 1'b0;
      rx_push       = 1'b0;
      rx_push_ok    = 1'b0;
      flush         = 1'b0;
      go_stop       = 1'b0;
      go_wr         = 1'b0;
      go_rd         = 1'b0;

      case (state)
         S_IDLE: begin
            if (abort) begin
               flush = 1'b1;
            end else if (go) begin
               w_saddr_nx = saddr;
               w_rnw_nx   = sfr_data_out[1];
               n_nx       = len;
               busy_nx    = 1'b1;
               state_nx   = S_START;
               req_nx     = 1'b1;
               cmd_nx     = CMD_START;
               ack_nx     = 1'b0;
            end
         end
         S_START: begin
            if (eng_done) begin
               if (abort_any) begin
                  go_stop = 1'b1;
               end else begin
                  state_nx = S_ADDR;
                  req_nx   = 1'b1;
                  cmd_nx   = CMD_WRITE;
                  wdata_nx = {w_saddr, w_rnw};
                  ack_nx   = 1'b0;
               end
            end
         end
         S_ADDR: begin
            if (eng_done) begin
               if (eng_nack) nack_nx = 1'b1;
               if (eng_nack || n == 4'd0 || abort_any) go_stop = 1'b1;
               else if (w_rnw)                         go_rd   = 1'b1;
               else                                    go_wr   = 1'b1;
            end
         end
         S_WR: begin
            if (eng_done) begin
               if (eng_nack) begin
                  nack_nx = 1'b1;
                  go_stop = 1'b1;
               end else begin
                  n_nx = n - 4'd1;
                  if (n_nx == 4'd0 || abort_any) go_stop = 1'b1;
                  else                           go_wr   = 1'b1;
               end
            end
         end
         S_WAIT_TX: begin
            if (abort_any) go_stop = 1'b1;
            else           go_wr   = 1'b1;
         end
         S_RD: begin
            if (eng_done) begin
               rx_push = 1'b1;
               n_nx    = n - 4'd1;
               if (n_nx == 4'd0 || abort_any) go_stop = 1'b1;
               else                           go_rd   = 1'b1;
            end
         end
         S_WAIT_RX: begin
            if (abort_any) go_stop = 1'b1;
            else           go_rd   = 1'b1;
         end
         S_STOP: begin
            if (eng_done) begin
               busy_nx       = 1'b0;
               done_nx       = 1'b1;
               state_nx      = S_IDLE;
               flush         = abort_any;
               abort_pend_nx = 1'b0;
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // RX side resolved first: a READ is only issued if its byte will have room
      rx_push_ok = rx_push && !flush && ((rx_cnt != FULL) || rx_pop);
      rx_cnt_nx  = flush ? '0 : CW'(rx_cnt + CW'(rx_push_ok) - CW'(rx_pop));
      rx_wp_nx   = flush ? '0 : (rx_push_ok ? AW'(rx_wp + AW'(1)) : rx_wp);
      rx_rp_nx   = flush ? '0 : (rx_pop ? AW'(rx_rp + AW'(1)) : rx_rp);

      if (go_stop) begin
         state_nx = S_STOP;
         req_nx   = 1'b1;
         cmd_nx   = CMD_STOP;
         ack_nx   = 1'b0;
      end else if (go_wr) begin
         if (tx_cnt == '0) begin
            state_nx = S_WAIT_TX;
         end else begin
            tx_pop   = 1'b1;
            state_nx = S_WR;
            req_nx   = 1'b1;
            cmd_nx   = CMD_WRITE;
            wdata_nx = tx_mem[tx_rp];
            ack_nx   = 1'b0;
         end
      end else if (go_rd) begin
         if (rx_cnt_nx == FULL) begin
            state_nx = S_WAIT_RX;
         end else begin
            state_nx = S_RD;
            req_nx   = 1'b1;
            cmd_nx   = CMD_READ;
            ack_nx   = (n_nx == 4'd1);
         end
      end

      tx_push = tx_wr && !flush && ((tx_cnt != FULL) || tx_pop);
      if (tx_wr && !flush && !tx_push) tx_ovf_nx = 1'b1;
      tx_cnt_nx = flush ? '0 : CW'(tx_cnt + CW'(tx_push) - CW'(tx_pop));
      tx_wp_nx  = flush ? '0 : (tx_push ? AW'(tx_wp + AW'(1)) : tx_wp);
      tx_rp_nx  = flush ? '0 : (tx_pop ? AW'(tx_rp + AW'(1)) : tx_rp);

      irq_nx = done_nx & irq_en_nx;
   end

   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         nack         <= 1'b0;
         tx_ovf       <= 1'b0;
         abort_pend   <= 1'b0;
         irq_en       <= 1'b0;
         saddr        <= '0;
         len          <= '0;
         w_saddr      <= '0;
         w_rnw        <= 1'b0;
         n            <= '0;
         eng_req      <= 1'b0;
         eng_cmd      <= CMD_START;
         eng_wdata    <= 8'h00;
         eng_ack_last <= 1'b0;
         irq          <= 1'b0;
         tx_wp        <= '0;
         tx_rp        <= '0;
         tx_cnt       <= '0;
         rx_wp        <= '0;
         rx_rp        <= '0;
         rx_cnt       <= '0;
      end else begin
         state        <= state_nx;
         busy         <= busy_nx;
         done         <= done_nx;
         nack         <= nack_nx;
         tx_ovf       <= tx_ovf_nx;
         abort_pend   <= abort_pend_nx;
         irq_en       <= irq_en_nx;
         saddr        <= saddr_nx;
         len          <= len_nx;
         w_saddr      <= w_saddr_nx;
         w_rnw        <= w_rnw_nx;
         n            <= n_nx;
         eng_req      <= req_nx;
         eng_cmd      <= cmd_nx;
         eng_wdata    <= wdata_nx;
         eng_ack_last <= ack_nx;
         irq          <= irq_nx;
         tx_wp        <= tx_wp_nx;
         tx_rp        <= tx_rp_nx;
         tx_cnt       <= tx_cnt_nx;
         rx_wp        <= rx_wp_nx;
         rx_rp        <= rx_rp_nx;
         rx_cnt       <= rx_cnt_nx;
      end
   end

   // FIFO storage needs no reset; occupancy is tracked by the counters
   always_ff @(posedge clk) begin
      if (tx_push)    tx_mem[tx_wp] <= sfr_data_out;
      if (rx_push_ok) rx_mem[rx_wp] <= eng_rdata;
   end

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Scoreboard bench for i2c_xfer_sequencer: expected engine commands and SFR read
// data are queued by the stimulus and checked by a monitor; a small engine model answers.
module tb_i2c_xfer_sequencer;

   localparam logic [7:0] A_CTRL = 8'h9A, A_STATUS = 8'h9B, A_TX = 8'h9C;
   localparam logic [7:0] A_RX = 8'h9D, A_SADDR = 8'h9E, A_LEN = 8'h9F;
   localparam logic [1:0] C_START = 2'b00, C_WRITE = 2'b01, C_READ = 2'b10, C_STOP = 2'b11;
   localparam int P_IRQ = 0, P_REQ = 1, P_CMD = 2, P_QLEN = 3, P_RDQ = 4;

   logic       clk = 1'b0;
   logic       rst_in_n, sfr_wr, sfr_rd;
   logic [7:0] sfr_addr, sfr_data_out, sfr_data_in;
   logic       eng_req, eng_ack_last, eng_done, eng_nack, irq;
   logic [1:0] eng_cmd;
   logic [7:0] eng_wdata, eng_rdata;

   typedef struct { logic [1:0] cmd; logic [7:0] wdata; logic ack; } cmd_t;
   typedef struct { string name; logic [7:0] val; } rd_t;
   typedef struct { string name; int sel; logic [7:0] val; } probe_t;

   cmd_t       cmd_q[$];
   rd_t        rd_q[$];
   probe_t     probe_q[$];
   logic [7:0] eng_data_q[$];
   int         errors = 0;
   int         checks = 0;
   bit         nack_arm = 1'b0;
   logic [1:0] eng_c;
   bit         eng_abort;

   always #5 clk = ~clk;

   i2c_xfer_sequencer #(.FIFO_DEPTH(4), .SFR_BASE(8'h9A)) dut (
      .clk(clk), .rst_in_n(rst_in_n), .sfr_wr(sfr_wr), .sfr_rd(sfr_rd),
      .sfr_addr(sfr_addr), .sfr_data_out(sfr_data_out), .sfr_data_in(sfr_data_in),
      .eng_req(eng_req), .eng_cmd(eng_cmd), .eng_wdata(eng_wdata),
      .eng_ack_last(eng_ack_last), .eng_done(eng_done), .eng_rdata(eng_rdata),
      .eng_nack(eng_nack), .irq(irq)
   );

   // Monitor: the only process that compares and counts
   always @(negedge clk) begin
      cmd_t       e;
      rd_t        r;
      probe_t     p;
      logic [7:0] act;
      if (rst_in_n && eng_req) begin
         checks++;
         if (cmd_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected: got cmd=%0d wdata=%02h required no command", eng_cmd, eng_wdata);
         end else begin
            e = cmd_q.pop_front();
            if (eng_cmd !== e.cmd || (e.cmd == C_WRITE && eng_wdata !== e.wdata) ||
                (e.cmd == C_READ && eng_ack_last !== e.ack)) begin
               errors++;
               $display("FAIL cmd: got cmd=%0d wdata=%02h ack_last=%0b required cmd=%0d wdata=%02h ack_last=%0b",
                        eng_cmd, eng_wdata, eng_ack_last, e.cmd, e.wdata, e.ack);
            end
         end
      end
      if (rst_in_n && sfr_rd) begin
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got %02h required no read", sfr_data_in);
         end else begin
            r = rd_q.pop_front();
            if (sfr_data_in !== r.val) begin
               errors++;
               $display("FAIL %s: got %02h required %02h", r.name, sfr_data_in, r.val);
            end
         end
      end
      while (probe_q.size() != 0) begin
         p = probe_q.pop_front();
         case (p.sel)
            P_IRQ:   act = {7'h00, irq};
            P_REQ:   act = {7'h00, eng_req};
            P_CMD:   act = {6'h00, eng_cmd};
            P_QLEN:  act = 8'(cmd_q.size());
            default: act = 8'(rd_q.size());
         endcase
         checks++;
         if (act !== p.val) begin
            errors++;
            $display("FAIL %s: got %02h required %02h", p.name, act, p.val);
         end
      end
   end

   // Byte-engine model: fixed latency, READ data and WRITE NACK from the bench
   initial begin
      eng_done = 1'b0; eng_rdata = 8'h00; eng_nack = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_in_n && eng_req) begin
            eng_c = eng_cmd;
            eng_abort = 1'b0;
            repeat (4) begin
               @(posedge clk);
               if (!rst_in_n) eng_abort = 1'b1;
            end
            if (!eng_abort) begin
               #1;
               eng_done  = 1'b1;
               eng_nack  = (eng_c == C_WRITE) && nack_arm;
               eng_rdata = 8'h00;
               if (eng_c == C_READ && eng_data_q.size() != 0) eng_rdata = eng_data_q.pop_front();
               @(posedge clk); #1;
               eng_done = 1'b0;
               eng_nack = 1'b0;
            end
         end
      end
   end

   task automatic exp_cmd(input logic [1:0] c, input logic [7:0] w, input logic a);
      cmd_t e;
      e.cmd = c; e.wdata = w; e.ack = a;
      cmd_q.push_back(e);
   endtask

   task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      sfr_wr = 1'b1; sfr_addr = a; sfr_data_out = d;
      @(posedge clk); #1;
      sfr_wr = 1'b0;
   endtask

   task automatic sfr_read(input logic [7:0] a, input logic [7:0] exp, input string name);
      rd_t r;
      r.name = name; r.val = exp;
      rd_q.push_back(r);
      @(posedge clk); #1;
      sfr_rd = 1'b1; sfr_addr = a;
      @(posedge clk); #1;
      sfr_rd = 1'b0;
   endtask

   task automatic probe(input string name, input int sel, input logic [7:0] val);
      probe_t p;
      p.name = name; p.sel = sel; p.val = val;
      probe_q.push_back(p);
      @(negedge clk); #1;
   endtask

   task automatic wait_q(input string name, input int budget);
      int k = 0;
      while (cmd_q.size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      probe(name, P_QLEN, 8'h00);
      cmd_q.delete();
   endtask

   task automatic settle(input int cyc);
      repeat (cyc) @(posedge clk);
   endtask

   initial begin
      rst_in_n = 1'b0; sfr_wr = 1'b0; sfr_rd = 1'b0; sfr_addr = 8'h00; sfr_data_out = 8'h00;
      settle(3);
      probe("rst_req", P_REQ, 8'h00);
      probe("rst_irq", P_IRQ, 8'h00);
      #2 rst_in_n = 1'b1;
      sfr_read(A_STATUS, 8'h08, "rst_status");

      // Two-byte write; SADDR bit 7 must be masked
      sfr_write(A_SADDR, 8'hD0);
      sfr_read(A_SADDR, 8'h50, "saddr_rb");
      sfr_write(A_LEN, 8'hF3);
      sfr_read(A_LEN, 8'h03, "len_rb");
      sfr_read(8'hA0, 8'h00, "unmapped_rd");
      sfr_write(A_LEN, 8'h02);
      sfr_write(A_TX, 8'hA5);
      sfr_write(A_TX, 8'h3C);
      exp_cmd(C_START, 8'h00, 1'b0); exp_cmd(C_WRITE, 8'hA0, 1'b0);
      exp_cmd(C_WRITE, 8'hA5, 1'b0); exp_cmd(C_WRITE, 8'h3C, 1'b0); exp_cmd(C_STOP, 8'h00, 1'b0);
      sfr_write(A_CTRL, 8'h01);
      wait_q("wr2_drain", 200); settle(8);
      sfr_read(A_STATUS, 8'h0A, "wr2_status");
      sfr_read(A_STATUS, 8'h08, "wr2_status_clr");

      // Three-byte read
      sfr_write(A_LEN, 8'h03);
      eng_data_q.push_back(8'h11); eng_data_q.push_back(8'h22); eng_data_q.push_back(8'h33);
      exp_cmd(C_START, 8'h00, 1'b0); exp_cmd(C_WRITE, 8'hA1, 1'b0);
      exp_cmd(C_READ, 8'h00, 1'b0); exp_cmd(C_READ, 8'h00, 1'b0); exp_cmd(C_READ, 8'h00, 1'b1);
      exp_cmd(C_STOP, 8'h00, 1'b0);
      sfr_write(A_CTRL, 8'h03);
      wait_q("rd3_drain", 200); settle(8);
      sfr_read(A_STATUS, 8'h1A, "rd3_status");
      sfr_read(A_RX, 8'h11, "rd3_b0");
      sfr_read(A_RX, 8'h22, "rd3_b1");
      sfr_read(A_RX, 8'h33, "rd3_b2");
      sfr_read(A_RX, 8'h00, "rd3_empty");

      // Address NACK
      sfr_write(A_LEN, 8'h02);
      nack_arm = 1'b1;
      exp_cmd(C_START, 8'h00, 1'b0); exp_cmd(C_WRITE, 8'hA0, 1'b0); exp_cmd(C_STOP, 8'h00, 1'b0);
      sfr_write(A_CTRL, 8'h01);
      wait_q("nack_drain", 200); settle(8);
      nack_arm = 1'b0;
      sfr_read(A_STATUS, 8'h0E, "nack_status");
      sfr_read(A_STATUS, 8'h08, "nack_status_clr");

      // TX backpressure, LEN=6 with four bytes queued
      sfr_write(A_LEN, 8'h06);
      for (int i = 1; i <= 4; i++) sfr_write(A_TX, 8'(i));
      exp_cmd(C_START, 8'h00, 1'b0); exp_cmd(C_WRITE, 8'hA0, 1'b0);
      for (int i = 1; i <= 4; i++) exp_cmd(C_WRITE, 8'(i), 1'b0);
      sfr_write(A_CTRL, 8'h01);
      wait_q("wtx_first4", 300); settle(20);
      sfr_read(A_STATUS, 8'h09, "wtx_stall_status");
      exp_cmd(C_WRITE, 8'h05, 1'b0); exp_cmd(C_WRITE, 8'h06, 1'b0); exp_cmd(C_STOP, 8'h00, 1'b0);
      sfr_write(A_TX, 8'h05);
      settle(3);
      sfr_write(A_TX, 8'h06);
      wait_q("wtx_resume", 300); settle(8);
      sfr_read(A_STATUS, 8'h0A, "wtx_status");

      // RX backpressure, LEN=6 into a 4-deep FIFO
      for (int i = 1; i <= 6; i++) eng_data_q.push_back(8'(8'h40 + i));
      exp_cmd(C_START, 8'h00, 1'b0); exp_cmd(C_WRITE, 8'hA1, 1'b0);
      for (int i = 1; i <= 4; i++) exp_cmd(C_READ, 8'h00, 1'b0);
      sfr_write(A_CTRL, 8'h03);
      wait_q("wrx_first4", 300); settle(20);
      sfr_read(A_STATUS, 8'h19, "wrx_stall_status");
      exp_cmd(C_READ, 8'h00, 1'b0); exp_cmd(C_READ, 8'h00, 1'b1); exp_cmd(C_STOP, 8'h00, 1'b0);
      sfr_read(A_RX, 8'h41, "wrx_b1");
      sfr_read(A_RX, 8'h42, "wrx_b2");
      wait_q("wrx_resume", 300); settle(8);
      for (int i = 3; i <= 6; i++) sfr_read(A_RX, 8'(8'h40 + i), "wrx_bn");
      sfr_read(A_RX, 8'h00, "wrx_empty");
      sfr_read(A_STATUS, 8'h0A, "wrx_status");

      // TX overflow drops the 5th byte; abort from WAIT_TX
      for (int i = 1; i <= 5; i++) sfr_write(A_TX, 8'(8'hB0 + i));
      sfr_read(A_STATUS, 8'h20, "ovf_status");
      sfr_write(A_LEN, 8'h05);
      exp_cmd(C_START, 8'h00, 1'b0); exp_cmd(C_WRITE, 8'hA0, 1'b0);
      for (int i = 1; i <= 4; i++) exp_cmd(C_WRITE, 8'(8'hB0 + i), 1'b0);
      sfr_write(A_CTRL, 8'h01);
      wait_q("ovf_drain", 300); settle(20);
      sfr_read(A_STATUS, 8'h09, "ovf_stall_status");
      exp_cmd(C_STOP, 8'h00, 1'b0);
      sfr_write(A_CTRL, 8'h80);
      wait_q("ovf_abort", 200); settle(8);
      sfr_read(A_STATUS, 8'h0A, "ovf_abort_status");

      // ABORT in IDLE flushes the TX FIFO
      sfr_write(A_TX, 8'hD1);
      sfr_read(A_STATUS, 8'h00, "idle_tx_loaded");
      sfr_write(A_CTRL, 8'h80);
      sfr_read(A_STATUS, 8'h08, "idle_abort_flush");

      // ABORT during the first data WRITE: it completes, then STOP and flush
      sfr_write(A_LEN, 8'h03);
      sfr_write(A_TX, 8'hC1); sfr_write(A_TX, 8'hC2); sfr_write(A_TX, 8'hC3);
      exp_cmd(C_START, 8'h00, 1'b0); exp_cmd(C_WRITE, 8'hA0, 1'b0); exp_cmd(C_WRITE, 8'hC1, 1'b0);
      sfr_write(A_CTRL, 8'h01);
      wait_q("abort_pre", 200);
      exp_cmd(C_STOP, 8'h00, 1'b0);
      sfr_write(A_CTRL, 8'h80);
      wait_q("abort_stop", 200); settle(8);
      sfr_read(A_STATUS, 8'h0A, "abort_status");

      // irq follows DONE when IRQ_EN is set (address-only probe)
      sfr_write(A_LEN, 8'h00);
      exp_cmd(C_START, 8'h00, 1'b0); exp_cmd(C_WRITE, 8'hA0, 1'b0); exp_cmd(C_STOP, 8'h00, 1'b0);
      sfr_write(A_CTRL, 8'h09);
      probe("irq_busy", P_IRQ, 8'h00);
      wait_q("irq_drain", 200); settle(8);
      probe("irq_set", P_IRQ, 8'h01);
      sfr_read(A_STATUS, 8'h0A, "irq_status");
      probe("irq_clr", P_IRQ, 8'h00);

      // Reset pulsed while a READ is outstanding
      sfr_write(A_LEN, 8'h02);
      eng_data_q.push_back(8'h77); eng_data_q.push_back(8'h88);
      exp_cmd(C_START, 8'h00, 1'b0); exp_cmd(C_WRITE, 8'hA1, 1'b0); exp_cmd(C_READ, 8'h00, 1'b0);
      sfr_write(A_CTRL, 8'h0B);
      wait_q("mid_read", 200);
      rst_in_n = 1'b0;
      probe("rst_mid_req", P_REQ, 8'h00);
      probe("rst_mid_cmd", P_CMD, 8'h00);
      probe("rst_mid_irq", P_IRQ, 8'h00);
      rst_in_n = 1'b1;
      eng_data_q.delete();
      settle(8);
      sfr_read(A_STATUS, 8'h08, "rst_mid_status");
      sfr_read(A_SADDR, 8'h00, "rst_mid_saddr");
      sfr_write(A_SADDR, 8'h50);
      exp_cmd(C_START, 8'h00, 1'b0); exp_cmd(C_WRITE, 8'hA0, 1'b0); exp_cmd(C_STOP, 8'h00, 1'b0);
      sfr_write(A_CTRL, 8'h01);
      wait_q("post_rst_drain", 200); settle(8);
      sfr_read(A_STATUS, 8'h0A, "post_rst_status");

      settle(2);
      probe("rd_q_empty", P_RDQ, 8'h00);
      probe("cmd_q_empty", P_QLEN, 8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
